hazard_fwd_ctrl: RTL
====================

Name: hazard_fwd_ctrl

Overview:
- Control producer for the pipeline's operand-forwarding and PC/bubble muxes.
- Compares ID-stage source registers against EX/MEM destinations and registers the forwarding selects into the ID/EX boundary, so they are valid while the instruction is in EX.
- Detects load-use hazards, taken branch/jump flushes and syscall halt.
- Drives PC hold, IF/ID hold/flush and ID/EX bubble.

Parameters:
- RW, 5, register index width
- CNT_W, 32, performance counter width (used only when HAZARD_PERF_EN is defined)

Ports:
- clk  in  1  pipeline clock, rising edge
- rst  in  1  asynchronous, active-high reset
- id_ra  in  RW  ID-stage source A index (already muxed for syscall/shift)
- id_rb  in  RW  ID-stage source B index
- id_use_ra  in  1  instruction in ID reads A
- id_use_rb  in  1  instruction in ID reads B
- ex_rw  in  RW  EX-stage destination (after RegDst/jal mux)
- ex_regwrite  in  1  EX instruction writes regfile
- ex_memtoreg  in  1  EX instruction is a load
- mem_rw  in  RW  MEM-stage destination
- mem_regwrite  in  1  MEM instruction writes regfile
- ex_jump  in  1  taken branch/jump resolved in EX
- ex_halt  in  1  syscall halt resolved in EX
- go  in  1  resume pulse from halt
- a_mem, a_wb, b_mem, b_wb  out  1 each  registered forwarding selects for EX
- pc_hold  out  1  freeze PC
- ifid_hold  out  1  freeze IF/ID register
- ifid_flush  out  1  clear IF/ID register
- idex_bubble  out  1  load NOP into ID/EX
- halted  out  1  FSM in HALT
- stall_cnt, flush_cnt, fwd_cnt  out  CNT_W each  performance counters

Behaviour:
- Reset (asynchronous, active-high): all four selects=0, state=RUN, halted=0, counters=0.
- Hazard detection (combinational, in RUN):
  - hitA_ex = id_use_ra & ex_regwrite & (ex_rw==id_ra) & (id_ra!=0); hitB_ex is analogous.
  - hitA_mem / hitB_mem use mem_rw and mem_regwrite; register 0 never matches.
  - Load-use: lu = ex_memtoreg & (hitA_ex | hitB_ex).
- Priority: rst > ex_jump > ex_halt > lu.
  - ex_jump: ifid_flush=1, idex_bubble=1. No hold. State stays RUN.
  - ex_halt (and no jump): next state HALT, idex_bubble=1.
  - lu: pc_hold=1, ifid_hold=1, idex_bubble=1 for exactly one cycle. On the next cycle the load sits in MEM and is picked up by the WB select.
- Selects registered each clock:
  - idex_bubble=1: all selects <=0.
  - Otherwise a_mem<=hitA_ex&~ex_memtoreg and a_wb<=hitA_mem&~(hitA_ex&~ex_memtoreg). B is symmetric.
  - Newer (MEM) source always wins; a_mem and a_wb are never both 1.
- Regfile write-before-read covers the WB-to-ID distance; this block does not handle it.
- FSM:
  - RUN -> HALT on ex_halt & ~ex_jump.
  - HALT: pc_hold=1, ifid_hold=1, idex_bubble=1, halted=1, selects held at 0. Older instructions drain normally.
  - HALT -> RUN on go. pc_hold is released in the same cycle go is sampled high.
  - go while in RUN: ignored.
- Reset mid-stall or mid-halt: immediate return to RUN with all outputs at 0.
- Outputs with no hazard: pc_hold, ifid_hold, ifid_flush and idex_bubble all 0.

Optional Feature:
- HAZARD_PERF_EN defined: the three counters are implemented.
  - stall_cnt +1 per cycle with pc_hold & ~halted.
  - flush_cnt +1 per cycle with ifid_flush.
  - fwd_cnt +1 per edge that loads any select=1.
  - All counters wrap at 2^CNT_W and clear on rst.
- HAZARD_PERF_EN undefined: no counter flops; counter outputs are tied to 0.

Decomposition:
- Package pipe_pkg holds:
  - RW
  - REG_ZERO=0, REG_RA=31
  - state enum {ST_RUN, ST_HALT}
  - forward-select encoding constants
- One natural sub-module: fwd_match. It takes one source index, its use bit, and both destination/regwrite/load pairs, and returns hit_ex, hit_mem and load-hit. It is instantiated for A and for B.

Test Plan:
- EX add writes r8, ID reads ra=8 -> next edge a_mem=1, a_wb=0, no hold.
- MEM writes r9 and EX writes r9, ID rb=9 -> b_mem=1, b_wb=0 (newest wins). With EX writing r10 instead -> b_wb=1.
- EX lw r5, ID ra=5 -> one cycle of pc_hold=ifid_hold=idex_bubble=1. Selects=0 on that edge, then a_wb=1 on the following edge.
- ex_jump=1 together with load-use and ex_halt -> only ifid_flush=idex_bubble=1, no hold, halted stays 0.
- ex_halt=1 -> halted=1 and pc_hold=1 until go pulses after 10 cycles. pc_hold drops on the go cycle. Assert rst mid-halt -> all outputs 0 immediately.
- Destination r0 with regwrite=1 and ID ra=0 -> no forward and no stall. With HAZARD_PERF_EN: counters match stall/flush/forward tallies over a random 1000-cycle run.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard/forwarding control slice.
// Contents:
//   RW                   register index width
//   REG_ZERO, REG_RA     architectural register numbers of note
//   state_e              hazard controller FSM states (ST_RUN, ST_HALT)
//   FWD_NONE/MEM/WB      per-operand forwarding select encoding {wb, mem}
//   fwd_sel()            picks the forwarding source for one operand
package pipe_pkg;

  localparam int RW = 5;

  localparam logic [RW-1:0] REG_ZERO = 5'd0;
  localparam logic [RW-1:0] REG_RA   = 5'd31;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

  // Bit 0 selects the EX/MEM result, bit 1 selects the MEM/WB result.
  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_MEM  = 2'b01;
  localparam logic [1:0] FWD_WB   = 2'b10;

  // The newer producer (the instruction one stage ahead, now in EX) wins.
  // A load in EX cannot forward yet, so it leaves the older MEM producer
  // as the candidate; the load-use stall bubbles that case away anyway.
  function automatic logic [1:0] fwd_sel(input logic hit_ex,
                                         input logic hit_mem,
                                         input logic ex_load);
    logic [1:0] sel;
    sel = FWD_NONE;
    if (hit_ex && !ex_load) begin
      sel = FWD_MEM;
    end else if (hit_mem) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_fwd_ctrl_fwd_match.sv
// Source-operand matcher for one ID-stage register read.
// Ports:
//   src_i, use_src_i           source index and whether it is actually read
//   ex_rw_i, ex_regwrite_i     EX-stage destination and write enable
//   ex_memtoreg_i              EX-stage instruction is a load
//   mem_rw_i, mem_regwrite_i   MEM-stage destination and write enable
//   hit_ex_o                   EX producer matches this source
//   hit_mem_o                  MEM producer matches this source
//   load_hit_o                 EX producer is a load that matches (load-use)
// Register zero is hardwired, so it never produces a match.
module fwd_match #(
  parameter int RW = pipe_pkg::RW
) (
  input  logic [RW-1:0] src_i,
  input  logic          use_src_i,
  input  logic [RW-1:0] ex_rw_i,
  input  logic          ex_regwrite_i,
  input  logic          ex_memtoreg_i,
  input  logic [RW-1:0] mem_rw_i,
  input  logic          mem_regwrite_i,
  output logic          hit_ex_o,
  output logic          hit_mem_o,
  output logic          load_hit_o
);
  import pipe_pkg::*;

  logic src_live;

  assign src_live   = use_src_i && (src_i != RW'(REG_ZERO));
  assign hit_ex_o   = src_live && ex_regwrite_i && (ex_rw_i == src_i);
  assign hit_mem_o  = src_live && mem_regwrite_i && (mem_rw_i == src_i);
  assign load_hit_o = hit_ex_o && ex_memtoreg_i;

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Hazard and forwarding control for the 5-stage pipeline.
// Registers the EX-stage forwarding selects at the ID/EX boundary and drives
// the PC hold, IF/ID hold/flush and ID/EX bubble controls for load-use
// stalls, taken branch/jump flushes and syscall halt.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   id_ra/id_rb, id_use_ra/rb     ID-stage sources and their use bits
//   ex_rw, ex_regwrite, ex_memtoreg   EX-stage producer
//   mem_rw, mem_regwrite          MEM-stage producer
//   ex_jump, ex_halt, go          redirect, halt request, resume pulse
//   a_mem/a_wb/b_mem/b_wb         registered forwarding selects for EX
//   pc_hold, ifid_hold, ifid_flush, idex_bubble, halted   pipeline controls
//   stall_cnt, flush_cnt, fwd_cnt performance counters
// Build option: define HAZARD_PERF_EN to implement the performance counters;
// otherwise they are tied to zero and no counter flops exist.
module hazard_fwd_ctrl #(
  parameter int RW    = pipe_pkg::RW,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [RW-1:0]    id_ra,
  input  logic [RW-1:0]    id_rb,
  input  logic             id_use_ra,
  input  logic             id_use_rb,
  input  logic [RW-1:0]    ex_rw,
  input  logic             ex_regwrite,
  input  logic             ex_memtoreg,
  input  logic [RW-1:0]    mem_rw,
  input  logic             mem_regwrite,
  input  logic             ex_jump,
  input  logic             ex_halt,
  input  logic             go,
  output logic             a_mem,
  output logic             a_wb,
  output logic             b_mem,
  output logic             b_wb,
  output logic             pc_hold,
  output logic             ifid_hold,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] fwd_cnt
);
  import pipe_pkg::*;

  state_e     state_q, state_d;
  logic       a_mem_q, a_wb_q, b_mem_q, b_wb_q;
  logic       a_mem_d, a_wb_d, b_mem_d, b_wb_d;
  logic       hit_a_ex, hit_a_mem, load_a;
  logic       hit_b_ex, hit_b_mem, load_b;
  logic       load_use, active;
  logic [1:0] sel_a, sel_b;

  fwd_match #(.RW(RW)) u_match_a (
    .src_i          (id_ra),
    .use_src_i      (id_use_ra),
    .ex_rw_i        (ex_rw),
    .ex_regwrite_i  (ex_regwrite),
    .ex_memtoreg_i  (ex_memtoreg),
    .mem_rw_i       (mem_rw),
    .mem_regwrite_i (mem_regwrite),
    .hit_ex_o       (hit_a_ex),
    .hit_mem_o      (hit_a_mem),
    .load_hit_o     (load_a)
  );

  fwd_match #(.RW(RW)) u_match_b (
    .src_i          (id_rb),
    .use_src_i      (id_use_rb),
    .ex_rw_i        (ex_rw),
    .ex_regwrite_i  (ex_regwrite),
    .ex_memtoreg_i  (ex_memtoreg),
    .mem_rw_i       (mem_rw),
    .mem_regwrite_i (mem_regwrite),
    .hit_ex_o       (hit_b_ex),
    .hit_mem_o      (hit_b_mem),
    .load_hit_o     (load_b)
  );

  assign load_use = load_a || load_b;

  // The go cycle already behaves like RUN, so the PC is released as soon
  // as go is sampled; halted stays high until the state register moves.
  assign active = (state_q == ST_RUN) || go;

  assign sel_a = fwd_sel(hit_a_ex, hit_a_mem, ex_memtoreg);
  assign sel_b = fwd_sel(hit_b_ex, hit_b_mem, ex_memtoreg);

  // Next state and pipeline controls. Outputs are forced low while reset is
  // asserted so that a reset in the middle of a stall or halt releases the
  // pipeline immediately rather than at the next edge.
  always_comb begin
    state_d     = state_q;
    pc_hold     = 1'b0;
    ifid_hold   = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    if (!rst) begin
      if (active) begin
        state_d = ST_RUN;
        if (ex_jump) begin
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
        end else if (ex_halt) begin
          state_d     = ST_HALT;
          idex_bubble = 1'b1;
        end else if (load_use) begin
          pc_hold     = 1'b1;
          ifid_hold   = 1'b1;
          idex_bubble = 1'b1;
        end
      end else begin
        pc_hold     = 1'b1;
        ifid_hold   = 1'b1;
        idex_bubble = 1'b1;
      end
    end
  end

  assign halted = (state_q == ST_HALT);

  // A bubble entering EX must not forward anything.
  always_comb begin
    a_mem_d = !idex_bubble && (sel_a == FWD_MEM);
    a_wb_d  = !idex_bubble && (sel_a == FWD_WB);
    b_mem_d = !idex_bubble && (sel_b == FWD_MEM);
    b_wb_d  = !idex_bubble && (sel_b == FWD_WB);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
      a_mem_q <= 1'b0;
      a_wb_q  <= 1'b0;
      b_mem_q <= 1'b0;
      b_wb_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_mem_q <= a_mem_d;
      a_wb_q  <= a_wb_d;
      b_mem_q <= b_mem_d;
      b_wb_q  <= b_wb_d;
    end
  end

  assign a_mem = a_mem_q;
  assign a_wb  = a_wb_q;
  assign b_mem = b_mem_q;
  assign b_wb  = b_wb_q;

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q, fwd_cnt_q;
  logic             any_fwd_d;

  assign any_fwd_d = a_mem_d || a_wb_d || b_mem_d || b_wb_d;

  // Halt cycles also hold the PC but are not counted as stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      if (pc_hold && !halted) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
      if (ifid_flush) begin
        flush_cnt_q <= flush_cnt_q + 1'b1;
      end
      if (any_fwd_d) begin
        fwd_cnt_q <= fwd_cnt_q + 1'b1;
      end
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
  assign fwd_cnt   = fwd_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
  assign fwd_cnt   = '0;
`endif

endmodule
